mac_simd: RTL
=============

Name: mac_simd

Overview:
- Parametrised two-stage signed multiply-accumulate unit; successor to the fixed 16-bit MAC.
- One compile-time maximum lane count (LANES); a per-instruction split bit selects full-width mode (one lane) or SIMD mode (LANES independent lanes).
- Adds multiply-subtract, valid tagging, a no-op, and sticky per-lane saturation flags.
- Sits in the datapath between the operand register file and the result writeback.

Parameters:
DATA_W, 16, operand width; must be divisible by LANES
LANES, 2, SIMD lane count in split mode (power of two, 1..8)
GUARD_W, 4, guard bits per lane; full mode has LANES*GUARD_W guard bits

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
stall  input  1  1 = freeze every register in the block
in_valid  input  1  instruction/operands valid this cycle
instruction  input  4  [3]=split (1=SIMD), [2:0]=op
multiplier  input  DATA_W  signed operand A (lane i = bits i*DATA_W/LANES upward)
multiplicand  input  DATA_W  signed operand B, same lane packing
result  output  2*DATA_W  accumulator low bits (lane i = bits i*2*DATA_W/LANES upward)
protect  output  LANES*GUARD_W  accumulator guard bits (lane i = bits i*GUARD_W upward)
out_valid  output  1  result/protect reflect a newly completed instruction
sat_flag  output  LANES  sticky saturation flag per lane

Behaviour:
- Reset (reset_n=0 at a clk edge): result, protect, sat_flag, out_valid, the stage-1 product register and the stage-1 op register all go to 0. Reset overrides stall. A reset mid-accumulation discards all state.
- Accumulator width: ACC_W = 2*DATA_W + LANES*GUARD_W.
  - Full mode: {protect, result} is one signed ACC_W value.
  - Split mode: lane i is {protect lane i, result lane i}, a signed 2*DATA_W/LANES + GUARD_W value.
- Stage 1 (cycle N, stall=0):
  - Register the product and the op. in_valid=0 registers op NOP.
  - Full mode: one signed DATA_W x DATA_W product, sign-extended to ACC_W.
  - Split mode: per-lane signed (DATA_W/LANES)^2 product, sign-extended into that lane's field.
- Stage 2 (cycle N+1, stall=0) applies the registered op to the accumulator. out_valid=1 that cycle only if the op came from a valid input.
  - 000 NOP: hold.
  - 001 CLR: zero the accumulator and all sat_flag bits.
  - 010 LOAD: accumulator = product.
  - 011 ACC: accumulator += product.
  - 100 SUB: accumulator -= product.
  - 101 SAT: clamp to the signed 2*DATA_W (full) or 2*DATA_W/LANES (lane) range. On a clamp, guard bits become sign extension and sat_flag is set (full mode sets all bits; split mode sets the clamped lane's bit).
  - 110, 111: reserved; treated as NOP.
- Latency: accumulator updated at the second rising edge after acceptance. Fully pipelined: one instruction per cycle, with back-to-back dependent ACCs allowed.
- Lane isolation: split-mode add/sub wraps modulo lane width with no carry across lanes. Full-mode overflow of ACC_W wraps silently.
- Mode mixing: split is honoured per instruction. The accumulator bits are reinterpreted without conversion when modes change.
- stall=1: both stages and all outputs hold, out_valid holds its value, and inputs are ignored. Release resumes exactly where the pipeline was.
- sat_flag is cleared only by CLR or reset.

Test Plan (DATA_W=16, LANES=2, GUARD_W=4):
1. Full-mode growth and saturation:
   - Stimulus: CLR, then 3x ACC of 0x7FFF*0x7FFF.
   - Required: result=0xBFFD0003, protect=0x00.
   - Then SAT: result=0x7FFFFFFF, protect=0x00, sat_flag=2'b11.
   - Then CLR: sat_flag=0.
2. Split-mode lane isolation:
   - Stimulus: multiplier=0x0203, multiplicand=0xFF04, op LOAD split=1.
   - Required: result=0xFFFE000C, protect=0xF0, out_valid=1 two edges after issue.
3. Multiply-subtract:
   - Stimulus: LOAD then SUB with 0x1234*0x0010 (full).
   - Required: result=0, protect=0. A second SUB gives result=0xFFFEDCC0, protect=0xFF.
4. Split saturation:
   - Stimulus: 10x ACC of lane-1 product 0x7F*0x7F (lane 0 = 1*1).
   - Required after SAT: lane1 result=0x7FFF, lane0 result=0x000A, sat_flag=2'b10.
5. Stall hold:
   - Stimulus: assert stall 3 cycles between two issued ACCs.
   - Required: outputs, out_valid and sat_flag unchanged during stall; the final sum equals the unstalled run.
6. Reset mid-operation:
   - Stimulus: reset_n=0 for one edge (with stall=1) while an ACC is in stage 1.
   - Required: all outputs 0 after the edge, and the pending ACC is not applied after release.

Source files
------------

// File: rtl/mac_simd.sv
// Two-stage signed multiply-accumulate with a per-instruction full/SIMD split.
// Stage 1 registers the sign-extended product; stage 2 applies the op to the accumulator.
module mac_simd #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 2,
  parameter int GUARD_W = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic                       in_valid,
  input  logic [3:0]                 instruction,
  input  logic [DATA_W-1:0]          multiplier,
  input  logic [DATA_W-1:0]          multiplicand,
  output logic [2*DATA_W-1:0]        result,
  output logic [LANES*GUARD_W-1:0]   protect,
  output logic                       out_valid,
  output logic [LANES-1:0]           sat_flag
);
  localparam int RES_W  = 2 * DATA_W;
  localparam int PROT_W = LANES * GUARD_W;
  localparam int ACC_W  = RES_W + PROT_W;
  localparam int LW     = DATA_W / LANES;
  localparam int LRW    = 2 * LW;
  localparam int LAW    = LRW + GUARD_W;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_CLR  = 3'b001,
    OP_LOAD = 3'b010,
    OP_ACC  = 3'b011,
    OP_SUB  = 3'b100,
    OP_SAT  = 3'b101
  } op_e;

  logic [RES_W-1:0]  prod_res_q, prod_res_d;
  logic [PROT_W-1:0] prod_prot_q, prod_prot_d;
  op_e               op_q, op_d;
  logic              split_q, split_d;
  logic              vld_q, vld_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [PROT_W-1:0] protect_q, protect_d;
  logic [LANES-1:0]  sat_q, sat_d;
  logic              out_valid_q, out_valid_d;

  logic [RES_W-1:0]  full_a, full_b, full_p;
  logic [LRW-1:0]    lane_a, lane_b, lane_p;

  // Stage 1: product in the same bit layout as the accumulator it will be applied to
  always_comb begin
    prod_res_d  = prod_res_q;
    prod_prot_d = prod_prot_q;
    op_d        = op_q;
    split_d     = split_q;
    vld_d       = vld_q;
    full_a      = {{DATA_W{multiplier[DATA_W-1]}}, multiplier};
    full_b      = {{DATA_W{multiplicand[DATA_W-1]}}, multiplicand};
    full_p      = full_a * full_b;
    lane_a      = '0;
    lane_b      = '0;
    lane_p      = '0;
    if (!stall) begin
      vld_d   = in_valid;
      split_d = instruction[3];
      op_d    = (in_valid && instruction[2:0] <= OP_SAT) ? op_e'(instruction[2:0]) : OP_NOP;
      if (instruction[3]) begin
        for (int i = 0; i < LANES; i++) begin
          lane_a = {{LW{multiplier[i*LW+LW-1]}}, multiplier[i*LW +: LW]};
          lane_b = {{LW{multiplicand[i*LW+LW-1]}}, multiplicand[i*LW +: LW]};
          lane_p = lane_a * lane_b;
          prod_res_d[i*LRW +: LRW]          = lane_p;
          prod_prot_d[i*GUARD_W +: GUARD_W] = {GUARD_W{lane_p[LRW-1]}};
        end
      end else begin
        prod_res_d  = full_p;
        prod_prot_d = {PROT_W{full_p[RES_W-1]}};
      end
    end
  end

  logic [ACC_W-1:0] acc_full, prod_full, sum_full;
  logic [LAW-1:0]   lane_acc, lane_prod, lane_sum;

  // Stage 2: saturation is detected by the guard bits plus the result MSB disagreeing
  always_comb begin
    result_d    = result_q;
    protect_d   = protect_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    acc_full    = {protect_q, result_q};
    prod_full   = {prod_prot_q, prod_res_q};
    sum_full    = acc_full;
    lane_acc    = '0;
    lane_prod   = '0;
    lane_sum    = '0;
    if (!stall) begin
      out_valid_d = vld_q;
      if (op_q == OP_CLR) begin
        result_d  = '0;
        protect_d = '0;
        sat_d     = '0;
      end else if (!split_q) begin
        case (op_q)
          OP_LOAD: sum_full = prod_full;
          OP_ACC:  sum_full = acc_full + prod_full;
          OP_SUB:  sum_full = acc_full - prod_full;
          OP_SAT: begin
            if (acc_full[ACC_W-1:RES_W-1] != {(PROT_W+1){acc_full[ACC_W-1]}}) begin
              sum_full = acc_full[ACC_W-1] ? {{(PROT_W+1){1'b1}}, {(RES_W-1){1'b0}}}
                                           : {{(PROT_W+1){1'b0}}, {(RES_W-1){1'b1}}};
              sat_d    = '1;
            end
          end
          default: ;
        endcase
        {protect_d, result_d} = sum_full;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          lane_acc  = {protect_q[i*GUARD_W +: GUARD_W], result_q[i*LRW +: LRW]};
          lane_prod = {prod_prot_q[i*GUARD_W +: GUARD_W], prod_res_q[i*LRW +: LRW]};
          lane_sum  = lane_acc;
          case (op_q)
            OP_LOAD: lane_sum = lane_prod;
            OP_ACC:  lane_sum = lane_acc + lane_prod;
            OP_SUB:  lane_sum = lane_acc - lane_prod;
            OP_SAT: begin
              if (lane_acc[LAW-1:LRW-1] != {(GUARD_W+1){lane_acc[LAW-1]}}) begin
                lane_sum = lane_acc[LAW-1] ? {{(GUARD_W+1){1'b1}}, {(LRW-1){1'b0}}}
                                           : {{(GUARD_W+1){1'b0}}, {(LRW-1){1'b1}}};
                sat_d[i] = 1'b1;
              end
            end
            default: ;
          endcase
          protect_d[i*GUARD_W +: GUARD_W] = lane_sum[LAW-1:LRW];
          result_d[i*LRW +: LRW]          = lane_sum[LRW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prod_res_q  <= '0;
      prod_prot_q <= '0;
      op_q        <= OP_NOP;
      split_q     <= 1'b0;
      vld_q       <= 1'b0;
      result_q    <= '0;
      protect_q   <= '0;
      sat_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      prod_res_q  <= prod_res_d;
      prod_prot_q <= prod_prot_d;
      op_q        <= op_d;
      split_q     <= split_d;
      vld_q       <= vld_d;
      result_q    <= result_d;
      protect_q   <= protect_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign protect   = protect_q;
  assign sat_flag  = sat_q;
  assign out_valid = out_valid_q;

endmodule
